// File: rtl/vec3_math_pkg.sv
// ---------------------------------------------------------------------------
// vec3_math_pkg
// Shared types and helpers for the pipelined 3-vector multiplier.
//   mode_e    : operation selector carried alongside each operand pair
//   clip_e    : result of a range check against a signed word width
//   PROD_W    : product width for the default 32-bit component width
//   ACC_W     : accumulator width (two guard bits above PROD_W)
//   prod_w()  : product width for an arbitrary component width
//   acc_w()   : accumulator width for an arbitrary component width
//   sat_clip(): classifies a wide signed value against a width-bit range
// ---------------------------------------------------------------------------
package vec3_math_pkg;

   typedef enum logic {
      MODE_CROSS = 1'b0,
      MODE_DOT   = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      CLIP_NONE = 2'b00,
      CLIP_HIGH = 2'b01,
      CLIP_LOW  = 2'b10
   } clip_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int PROD_W         = 2 * DEF_DATA_WIDTH;
   localparam int ACC_W          = PROD_W + 2;

   // Widest value sat_clip can classify; must cover any accumulator in use.
   localparam int SAT_W = 128;

   function automatic int prod_w(input int data_width);
      return 2 * data_width;
   endfunction

   function automatic int acc_w(input int data_width);
      return (2 * data_width) + 2;
   endfunction

   // Reports whether value lies above, below or inside the signed range
   // of a width-bit word. The caller picks the clamp word from the code.
   function automatic clip_e sat_clip(input logic signed [SAT_W-1:0] value,
                                      input int width);
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
      min_v = ~max_v;
      if (value > max_v) begin
         return CLIP_HIGH;
      end else if (value < min_v) begin
         return CLIP_LOW;
      end else begin
         return CLIP_NONE;
      end
   endfunction

endpackage

// File: rtl/vec3_round_sat.sv
// ---------------------------------------------------------------------------
// vec3_round_sat
// Per-lane combinational rescale logic, split in two independent halves so
// the top can put a register between them:
//   acc        in  ACC_W       signed accumulator (difference or dot sum)
//   shifted    out ACC_W       acc with optional half-LSB bias, >>> Q_BITS
//   shifted_in in  ACC_W       registered copy of a previous 'shifted'
//   res        out DATA_WIDTH  shifted_in clamped (SATURATE=1) or wrapped
//   sat        out 1           shifted_in was out of range and got clamped
// ---------------------------------------------------------------------------
module vec3_round_sat
   import vec3_math_pkg::*;
#(
   parameter int ACC_W      = 66,
   parameter int DATA_WIDTH = 32,
   parameter int Q_BITS     = 10,
   parameter int ROUND      = 1,
   parameter int SATURATE   = 1
) (
   input  logic [ACC_W-1:0]      acc,
   output logic [ACC_W-1:0]      shifted,
   input  logic [ACC_W-1:0]      shifted_in,
   output logic [DATA_WIDTH-1:0] res,
   output logic                  sat
);

   localparam int BIAS_SH = (Q_BITS > 0) ? (Q_BITS - 1) : 0;
   // Half an output LSB; zero when truncating so the shift floors to -inf.
   localparam logic [ACC_W-1:0] BIAS = ((ROUND != 0) && (Q_BITS > 0)) ?
                                       (ACC_W'(1) << BIAS_SH) : {ACC_W{1'b0}};

   localparam logic [DATA_WIDTH-1:0] MAX_WORD = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_WORD = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_W-1:0] rounded;
   clip_e                   clip;

   // The accumulator has guard bits, so adding the bias cannot overflow.
   assign rounded = $signed(acc) + $signed(BIAS);
   assign shifted = rounded >>> Q_BITS;

   // Clamp to the signed output range or keep the low bits.
   always_comb begin
      clip = sat_clip(SAT_W'($signed(shifted_in)), DATA_WIDTH);
      res  = shifted_in[DATA_WIDTH-1:0];
      sat  = 1'b0;
      if (SATURATE != 0) begin
         case (clip)
            CLIP_HIGH: begin
               res = MAX_WORD;
               sat = 1'b1;
            end
            CLIP_LOW: begin
               res = MIN_WORD;
               sat = 1'b1;
            end
            default: begin
               res = shifted_in[DATA_WIDTH-1:0];
               sat = 1'b0;
            end
         endcase
      end else begin
         res = shifted_in[DATA_WIDTH-1:0];
         sat = 1'b0;
      end
   end

endmodule

// File: rtl/vec3_mul_pipe.sv
// ---------------------------------------------------------------------------
// vec3_mul_pipe
// Three-stage fixed-point 3-vector multiplier (cross or dot product) between
// an FWFT input FIFO pair and an output FIFO.
//   clock      in  1             system clock
//   reset      in  1             synchronous active-high reset, drops in-flight ops
//   x, y       in  3xDATA_WIDTH  signed operand vectors, valid while in_empty=0
//   mode       in  1             0 = cross, 1 = dot; consumed with x/y
//   in_empty   in  1             input FIFO empty
//   in_rd_en   out 1             pop input FIFO this cycle
//   out_full   in  1             output FIFO full
//   out        out 3xDATA_WIDTH  result; dot product in out[0], others 0
//   out_wr_en  out 1             push out into output FIFO
//   sat_flag   out 1             some checked lane of out was clamped
// Stages: S1 products, S2 combine + round + shift, S3 saturate/wrap.
// The whole pipe stalls together while a finished result waits on out_full.
// ---------------------------------------------------------------------------
module vec3_mul_pipe
   import vec3_math_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int Q_BITS     = 10,
   parameter int ROUND      = 1,
   parameter int SATURATE   = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [2:0][DATA_WIDTH-1:0] x,
   input  logic [2:0][DATA_WIDTH-1:0] y,
   input  logic                       mode,
   input  logic                       in_empty,
   output logic                       in_rd_en,
   input  logic                       out_full,
   output logic [2:0][DATA_WIDTH-1:0] out,
   output logic                       out_wr_en,
   output logic                       sat_flag
);

   localparam int LANE_PROD_W = prod_w(DATA_WIDTH);
   localparam int LANE_ACC_W  = acc_w(DATA_WIDTH);

   logic advance;

   logic signed [LANE_PROD_W-1:0] xe    [3];
   logic signed [LANE_PROD_W-1:0] ye    [3];
   logic signed [LANE_PROD_W-1:0] a_op  [6];
   logic signed [LANE_PROD_W-1:0] b_op  [6];
   logic signed [LANE_PROD_W-1:0] prod  [6];

   logic                          s1_valid;
   mode_e                         s1_mode;
   logic signed [LANE_PROD_W-1:0] s1_prod [6];

   logic signed [LANE_ACC_W-1:0]  acc     [3];
   logic        [LANE_ACC_W-1:0]  shifted [3];

   logic                          s2_valid;
   mode_e                         s2_mode;
   logic        [LANE_ACC_W-1:0]  s2_val  [3];

   logic        [DATA_WIDTH-1:0]  res      [3];
   logic                          lane_sat [3];
   logic                          sat_any;

   logic                          s3_valid;

   // A finished result blocks the pipe only while the output FIFO is full.
   assign advance   = ~s3_valid | ~out_full;
   assign in_rd_en  = ~in_empty & advance & ~reset;
   assign out_wr_en = s3_valid & ~out_full & ~reset;

   // Sign-extend operands to product width before multiplying.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         xe[i] = LANE_PROD_W'($signed(x[i]));
         ye[i] = LANE_PROD_W'($signed(y[i]));
      end
   end

   // Steer operand pairs into the six multipliers. Cross uses all six as
   // minuend/subtrahend pairs; dot uses the even ones for the diagonal terms.
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         a_op[k] = {LANE_PROD_W{1'b0}};
         b_op[k] = {LANE_PROD_W{1'b0}};
      end
      case (mode_e'(mode))
         MODE_CROSS: begin
            a_op[0] = xe[1]; b_op[0] = ye[2];
            a_op[1] = xe[2]; b_op[1] = ye[1];
            a_op[2] = xe[2]; b_op[2] = ye[0];
            a_op[3] = xe[0]; b_op[3] = ye[2];
            a_op[4] = xe[0]; b_op[4] = ye[1];
            a_op[5] = xe[1]; b_op[5] = ye[0];
         end
         MODE_DOT: begin
            a_op[0] = xe[0]; b_op[0] = ye[0];
            a_op[2] = xe[1]; b_op[2] = ye[1];
            a_op[4] = xe[2]; b_op[4] = ye[2];
         end
         default: begin
            for (int k = 0; k < 6; k++) begin
               a_op[k] = {LANE_PROD_W{1'b0}};
               b_op[k] = {LANE_PROD_W{1'b0}};
            end
         end
      endcase
   end

   // Six parallel multipliers; a full-width product of two sign-extended
   // words is exact.
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         prod[k] = a_op[k] * b_op[k];
      end
   end

   // S1: capture products and the mode that travels with them.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_mode  <= MODE_CROSS;
         for (int k = 0; k < 6; k++) begin
            s1_prod[k] <= {LANE_PROD_W{1'b0}};
         end
      end else if (advance) begin
         s1_valid <= in_rd_en;
         s1_mode  <= mode_e'(mode);
         for (int k = 0; k < 6; k++) begin
            s1_prod[k] <= prod[k];
         end
      end
   end

   // Combine products at accumulator width: three cross differences, or the
   // dot sum in lane 0 with lanes 1 and 2 forced to zero.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         acc[i] = {LANE_ACC_W{1'b0}};
      end
      case (s1_mode)
         MODE_CROSS: begin
            acc[0] = LANE_ACC_W'(s1_prod[0]) - LANE_ACC_W'(s1_prod[1]);
            acc[1] = LANE_ACC_W'(s1_prod[2]) - LANE_ACC_W'(s1_prod[3]);
            acc[2] = LANE_ACC_W'(s1_prod[4]) - LANE_ACC_W'(s1_prod[5]);
         end
         MODE_DOT: begin
            acc[0] = LANE_ACC_W'(s1_prod[0]) + LANE_ACC_W'(s1_prod[2])
                   + LANE_ACC_W'(s1_prod[4]);
         end
         default: begin
            for (int i = 0; i < 3; i++) begin
               acc[i] = {LANE_ACC_W{1'b0}};
            end
         end
      endcase
   end

   // Each lane rounds/shifts into S2 and saturates out of S2 into S3.
   for (genvar lane = 0; lane < 3; lane++) begin : g_lane
      vec3_round_sat #(
         .ACC_W      (LANE_ACC_W),
         .DATA_WIDTH (DATA_WIDTH),
         .Q_BITS     (Q_BITS),
         .ROUND      (ROUND),
         .SATURATE   (SATURATE)
      ) u_round_sat (
         .acc        (acc[lane]),
         .shifted    (shifted[lane]),
         .shifted_in (s2_val[lane]),
         .res        (res[lane]),
         .sat        (lane_sat[lane])
      );
   end

   // S2: capture the rescaled lanes.
   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_mode  <= MODE_CROSS;
         for (int i = 0; i < 3; i++) begin
            s2_val[i] <= {LANE_ACC_W{1'b0}};
         end
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         for (int i = 0; i < 3; i++) begin
            s2_val[i] <= shifted[i];
         end
      end
   end

   // Dot results only carry information in lane 0, so only it can flag.
   assign sat_any = lane_sat[0] |
                    ((s2_mode == MODE_CROSS) & (lane_sat[1] | lane_sat[2]));

   // S3: registered result. Bubbles leave the last result in place.
   always_ff @(posedge clock) begin
      if (reset) begin
         s3_valid <= 1'b0;
         out      <= '0;
         sat_flag <= 1'b0;
      end else if (advance) begin
         s3_valid <= s2_valid;
         if (s2_valid) begin
            for (int i = 0; i < 3; i++) begin
               out[i] <= res[i];
            end
            sat_flag <= sat_any;
         end
      end
   end

endmodule

// File: tb/tb_vec3_mul_pipe.sv
// Bench for vec3_mul_pipe: three instances (default, ROUND=0, SATURATE=0)
// share one stimulus stream; a queue-based reference computes each result
// with wide integer arithmetic and tracks where each op must appear.
module tb_vec3_mul_pipe;

   localparam int DW = 32;
   typedef logic [2:0][DW-1:0] vec_t;

   typedef struct {
      vec_t x;
      vec_t y;
      logic mode;
      int   age;
      int   pop_cycle;
      bit   lit_en;
      vec_t lit;
      logic lit_sat;
      bit   lat_chk;
   } op_t;

   logic clock = 1'b0;
   logic reset;
   vec_t x;
   vec_t y;
   logic mode;
   logic in_empty;
   logic out_full;

   logic rd  [3];
   logic wr  [3];
   logic sf  [3];
   vec_t o   [3];

   bit cfg_round [3] = '{1'b1, 1'b0, 1'b1};
   bit cfg_sat   [3] = '{1'b1, 1'b1, 1'b0};

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int n_writes = 0;
   bit pop_pending = 1'b0;
   bit mon_en = 1'b0;
   bit rst_req = 1'b1;
   int full_from = -1;
   int full_to = -2;

   op_t src [$];
   op_t pipe [$];

   always #5 clock = ~clock;

   vec3_mul_pipe u_dut (
      .clock(clock), .reset(reset), .x(x), .y(y), .mode(mode),
      .in_empty(in_empty), .in_rd_en(rd[0]), .out_full(out_full),
      .out(o[0]), .out_wr_en(wr[0]), .sat_flag(sf[0]));

   vec3_mul_pipe #(.ROUND(0)) u_rnd0 (
      .clock(clock), .reset(reset), .x(x), .y(y), .mode(mode),
      .in_empty(in_empty), .in_rd_en(rd[1]), .out_full(out_full),
      .out(o[1]), .out_wr_en(wr[1]), .sat_flag(sf[1]));

   vec3_mul_pipe #(.SATURATE(0)) u_wrap (
      .clock(clock), .reset(reset), .x(x), .y(y), .mode(mode),
      .in_empty(in_empty), .in_rd_en(rd[2]), .out_full(out_full),
      .out(o[2]), .out_wr_en(wr[2]), .sat_flag(sf[2]));

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic vec_t v3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
      vec_t v;
      v[0] = a0; v[1] = a1; v[2] = a2;
      return v;
   endfunction

   function automatic op_t mk(input vec_t a, input vec_t b, input logic m);
      op_t r;
      r.x = a; r.y = b; r.mode = m; r.age = 0; r.pop_cycle = 0;
      r.lit_en = 1'b0; r.lit = '0; r.lit_sat = 1'b0; r.lat_chk = 1'b0;
      return r;
   endfunction

   // Reference result straight from the arithmetic definition.
   function automatic void model(input op_t p, input bit rnd, input bit sat,
                                 output vec_t r, output logic sflag);
      logic signed [127:0] xs [3];
      logic signed [127:0] ys [3];
      logic signed [127:0] a  [3];
      logic signed [127:0] maxv;
      logic signed [127:0] minv;
      maxv = 128'sd2147483647;
      minv = -128'sd2147483648;
      for (int i = 0; i < 3; i++) begin
         xs[i] = {{96{p.x[i][DW-1]}}, p.x[i]};
         ys[i] = {{96{p.y[i][DW-1]}}, p.y[i]};
      end
      if (p.mode) begin
         a[0] = xs[0]*ys[0] + xs[1]*ys[1] + xs[2]*ys[2];
         a[1] = 128'sd0;
         a[2] = 128'sd0;
      end else begin
         a[0] = xs[1]*ys[2] - xs[2]*ys[1];
         a[1] = xs[2]*ys[0] - xs[0]*ys[2];
         a[2] = xs[0]*ys[1] - xs[1]*ys[0];
      end
      sflag = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (rnd) a[i] = a[i] + 128'sd512;
         a[i] = a[i] >>> 10;
         if (sat && a[i] > maxv) begin
            r[i] = 32'h7FFFFFFF; sflag = 1'b1;
         end else if (sat && a[i] < minv) begin
            r[i] = 32'h80000000; sflag = 1'b1;
         end else begin
            r[i] = a[i][31:0];
         end
      end
   endfunction

   task automatic tick();
      op_t d;
      @(posedge clock);
      #1;
      cycle++;
      if (pop_pending && src.size() > 0) d = src.pop_front();
      pop_pending = 1'b0;
      reset = rst_req;
      out_full = (cycle >= full_from) && (cycle <= full_to);
      in_empty = (src.size() == 0);
      if (src.size() > 0) begin
         x = src[0].x; y = src[0].y; mode = src[0].mode;
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((pipe.size() > 0 || src.size() > 0 || !in_empty) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s: drain not reached within %0d cycles", name, budget);
      end
   endtask

   // Per-cycle comparison of all three instances against the reference.
   always @(negedge clock) begin
      bit   front3;
      bit   exp_wr;
      bit   exp_rd;
      vec_t ev;
      logic es;
      op_t  n;
      if (mon_en) begin
         front3 = (pipe.size() > 0) && (pipe[0].age == 3);
         exp_wr = front3 && !out_full && !reset;
         exp_rd = !in_empty && !reset && !(front3 && out_full);
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("in_rd_en[%0d]", d), rd[d], exp_rd);
            chk($sformatf("out_wr_en[%0d]", d), wr[d], exp_wr);
            if (front3 && !reset) begin
               model(pipe[0], cfg_round[d], cfg_sat[d], ev, es);
               chk($sformatf("out[%0d]", d), o[d], ev);
               chk($sformatf("sat_flag[%0d]", d), sf[d], es);
            end
         end
         if (exp_wr && pipe[0].lit_en) begin
            chk("literal_out", o[0], pipe[0].lit);
            chk("literal_sat", sf[0], pipe[0].lit_sat);
         end
         if (exp_wr && pipe[0].lat_chk) begin
            chk("latency", cycle - pipe[0].pop_cycle, 3);
         end
         if (wr[0]) n_writes++;
         if (rd[0]) pop_pending = 1'b1;
         // Advance the reference to the state after the coming edge.
         if (reset) begin
            pipe.delete();
         end else if (!(front3 && out_full)) begin
            if (front3) void'(pipe.pop_front());
            foreach (pipe[i]) pipe[i].age++;
            if (exp_rd && src.size() > 0) begin
               n = src[0];
               n.age = 1;
               n.pop_cycle = cycle;
               pipe.push_back(n);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      op_t  p;
      vec_t mv;
      logic ms;
      int   w0;
      reset = 1'b1; in_empty = 1'b1; out_full = 1'b0;
      x = '0; y = '0; mode = 1'b0;

      tick();
      mon_en = 1'b1;
      tick();
      tick();
      rst_req = 1'b0;
      tick();
      @(negedge clock);
      chk("reset_out", o[0], 96'd0);
      chk("reset_wr", wr[0], 1'b0);
      chk("reset_rd", rd[0], 1'b0);
      chk("reset_sat", sf[0], 1'b0);

      // Reference pins from hand arithmetic.
      p = mk(v3(32'd1, 32'd0, 32'd0), v3(32'd0, 32'd512, 32'd0), 1'b0);
      model(p, 1'b0, 1'b1, mv, ms);
      chk("pin_trunc_512", mv[2], 32'd0);
      p = mk(v3(32'd1, 32'd0, 32'd0), v3(32'd0, -32'sd513, 32'd0), 1'b0);
      model(p, 1'b0, 1'b1, mv, ms);
      chk("pin_trunc_m513", mv[2], 32'hFFFFFFFF);
      p = mk(v3(32'd0, 32'h40000000, 32'd0), v3(32'd0, 32'd0, 32'h40000000), 1'b0);
      model(p, 1'b1, 1'b0, mv, ms);
      chk("pin_wrap_out0", mv[0], 32'd0);
      chk("pin_wrap_sat", ms, 1'b0);

      // Directed ops with literal expectations for the default instance.
      p = mk(v3(32'd1024, 32'd0, 32'd0), v3(32'd0, 32'd1024, 32'd0), 1'b0);
      p.lit_en = 1'b1; p.lit = v3(32'd0, 32'd0, 32'd1024); p.lat_chk = 1'b1;
      src.push_back(p);
      p = mk(v3(32'd1024, 32'd2048, 32'd3072), v3(32'd1024, 32'd1024, 32'd1024), 1'b1);
      p.lit_en = 1'b1; p.lit = v3(32'd6144, 32'd0, 32'd0);
      src.push_back(p);
      p = mk(v3(32'd1, 32'd0, 32'd0), v3(32'd0, 32'd512, 32'd0), 1'b0);
      p.lit_en = 1'b1; p.lit = v3(32'd0, 32'd0, 32'd1);
      src.push_back(p);
      p = mk(v3(32'd1, 32'd0, 32'd0), v3(32'd0, -32'sd512, 32'd0), 1'b0);
      p.lit_en = 1'b1; p.lit = v3(32'd0, 32'd0, 32'd0);
      src.push_back(p);
      p = mk(v3(32'd1, 32'd0, 32'd0), v3(32'd0, -32'sd513, 32'd0), 1'b0);
      p.lit_en = 1'b1; p.lit = v3(32'd0, 32'd0, 32'hFFFFFFFF);
      src.push_back(p);
      p = mk(v3(32'd0, 32'h40000000, 32'd0), v3(32'd0, 32'd0, 32'h40000000), 1'b0);
      p.lit_en = 1'b1; p.lit = v3(32'h7FFFFFFF, 32'd0, 32'd0); p.lit_sat = 1'b1;
      src.push_back(p);
      wait_drain("directed", 100);

      // Back-to-back mixed stream with out_full high for stream cycles 4-9.
      w0 = n_writes;
      full_from = cycle + 1 + 4;
      full_to   = cycle + 1 + 9;
      src.push_back(mk(v3(32'd3072, -32'sd2048, 32'd5120), v3(-32'sd1024, 32'd4096, 32'd7), 1'b0));
      src.push_back(mk(v3(-32'sd3000, 32'd1500, -32'sd77), v3(32'd2222, -32'sd999, 32'd123456), 1'b1));
      src.push_back(mk(v3(32'h80000000, 32'h80000000, 32'd0), v3(32'h80000000, 32'h80000000, 32'd0), 1'b1));
      src.push_back(mk(v3(32'd0, 32'h80000000, 32'd0), v3(32'd0, 32'd0, 32'h7FFFFFFF), 1'b0));
      src.push_back(mk(v3(32'd12345, -32'sd6789, 32'd4242), v3(-32'sd321, 32'd98765, -32'sd5555), 1'b0));
      src.push_back(mk(v3(32'd0, 32'd0, 32'd0), v3(32'd7, 32'd8, 32'd9), 1'b1));
      src.push_back(mk(v3(32'd1, 32'd0, 32'd0), v3(32'd0, 32'd1536, 32'd0), 1'b0));
      src.push_back(mk(v3(-32'sd70000, 32'd65536, 32'd3), v3(32'd40000, 32'd90000, -32'sd1), 1'b1));
      wait_drain("backpressure", 100);
      chk("bp_write_count", n_writes - w0, 8);
      full_from = -1; full_to = -2;

      // in_empty falls in the same cycle out_full rises with a result waiting.
      w0 = n_writes;
      src.push_back(mk(v3(32'd2048, 32'd1024, 32'd0), v3(32'd0, 32'd3072, 32'd1024), 1'b0));
      tick();
      tick();
      tick();
      full_from = cycle + 1;
      full_to   = cycle + 3;
      src.push_back(mk(v3(32'd5, 32'd6, 32'd7), v3(32'd1024, 32'd2048, 32'd4096), 1'b1));
      src.push_back(mk(v3(-32'sd4096, 32'd100, 32'd9), v3(32'd33, -32'sd2048, 32'd512), 1'b0));
      src.push_back(mk(v3(32'd777, 32'd888, 32'd999), v3(-32'sd1, -32'sd2, -32'sd3), 1'b1));
      wait_drain("simultaneous", 100);
      chk("sim_write_count", n_writes - w0, 4);
      full_from = -1; full_to = -2;

      // One-cycle reset with three ops in flight.
      w0 = n_writes;
      for (int i = 0; i < 5; i++) begin
         p = mk(v3(32'd1024 * (i + 1), 32'd3, 32'd0), v3(32'd5, 32'd1024, 32'd2048), 1'(i % 2));
         if (i == 3) p.lat_chk = 1'b1;
         src.push_back(p);
      end
      tick();
      tick();
      tick();
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      tick();
      @(negedge clock);
      chk("post_reset_out", o[0], 96'd0);
      chk("post_reset_sat", sf[0], 1'b0);
      wait_drain("reset_midstream", 100);
      chk("reset_write_count", n_writes - w0, 2);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
